// File: rtl/len5_pkg.sv
// Shared CDB types: result payload carried on the common data bus and the
// fixed execution-unit index map used by the arbiters.
package len5_pkg;

    localparam int MAX_EU_N  = 7;
    localparam int ROB_DEPTH = 32;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [63:0]          res_value;
        logic                 except_raised;
        logic [5:0]           except_code;
    } cdb_data_t;

    typedef enum logic [2:0] {
        LDBUFF = 3'd0,
        STBUFF = 3'd1,
        BU     = 3'd2,
        ALU    = 3'd3,
        MULT   = 3'd4,
        DIV    = 3'd5,
        FPU    = 3'd6
    } eu_idx_t;

endpackage

// File: rtl/rr_prio_encoder.sv
// Rotating-priority encoder: one-hot grant to the first requester found
// starting at ptr and wrapping modulo EU_N. Purely combinational.
module rr_prio_encoder #(
    parameter int EU_N = 7
) (
    input  logic [EU_N-1:0]         req,
    input  logic [$clog2(EU_N)-1:0] ptr,
    output logic [EU_N-1:0]         grant
);

    localparam int PTR_W = $clog2(EU_N);

    int               idx;
    logic [PTR_W-1:0] sel;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < EU_N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= EU_N) idx = idx - EU_N;
            sel = PTR_W'(idx);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB among the execution units.
// Define LEN5_CDB_SPILL_EN to insert a one-entry output register (1-cycle latency).
module cdb_arbiter
    import len5_pkg::*;
#(
    parameter int EU_N = MAX_EU_N
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [EU_N-1:0] eu_valid_i,
    output logic [EU_N-1:0] eu_ready_o,
    input  cdb_data_t       eu_data_i [EU_N],
    output logic            cdb_valid_o,
    input  logic            cdb_ready_i,
    output cdb_data_t       cdb_data_o,
    output logic [EU_N-1:0] cdb_grant_o
);

    localparam int PTR_W = $clog2(EU_N);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_next;
    logic [EU_N-1:0]  grant_raw;
    logic [EU_N-1:0]  grant;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [EU_N-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < EU_N; i++)
            if (oh[i]) idx = PTR_W'(i);
        return idx;
    endfunction

    rr_prio_encoder #(.EU_N(EU_N)) u_prio (
        .req   (eu_valid_i),
        .ptr   (rr_ptr),
        .grant (grant_raw)
    );

    assign grant    = flush_i ? '0 : grant_raw;
    assign gnt_idx  = onehot_to_idx(grant_raw);
    assign ptr_next = (gnt_idx == PTR_W'(EU_N - 1)) ? '0 : gnt_idx + PTR_W'(1);

`ifdef LEN5_CDB_SPILL_EN
    logic            reg_valid;
    cdb_data_t       reg_data;
    logic [EU_N-1:0] reg_grant;
    logic            eu_xfer;

    // The spill cell can take a new result whenever it is empty or draining.
    assign eu_ready_o  = grant & {EU_N{~reg_valid | cdb_ready_i}};
    assign eu_xfer     = |eu_ready_o;
    assign cdb_valid_o = reg_valid;
    assign cdb_data_o  = reg_data;
    assign cdb_grant_o = reg_grant;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr    <= '0;
            reg_valid <= 1'b0;
            reg_data  <= '0;
            reg_grant <= '0;
        end else if (flush_i) begin
            reg_valid <= 1'b0;
            reg_grant <= '0;
        end else if (eu_xfer) begin
            reg_valid <= 1'b1;
            reg_data  <= eu_data_i[gnt_idx];
            reg_grant <= grant;
            rr_ptr    <= ptr_next;
        end else if (reg_valid && cdb_ready_i) begin
            reg_valid <= 1'b0;
            reg_grant <= '0;
        end
    end
`else
    assign cdb_valid_o = |eu_valid_i & ~flush_i;
    assign cdb_data_o  = eu_data_i[gnt_idx];
    assign cdb_grant_o = grant;
    assign eu_ready_o  = grant & {EU_N{cdb_ready_i}};

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            rr_ptr <= '0;
        else if (cdb_valid_o && cdb_ready_i)
            rr_ptr <= ptr_next;
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of single-cycle vectors for the
// combinational build, plus hand-written reset and spill-register sequences.
module tb_cdb_arbiter;
    import len5_pkg::*;

    localparam int N = MAX_EU_N;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush = 1'b0;
    logic          cdb_ready = 1'b0;
    logic          cdb_valid;
    logic [N-1:0]  eu_valid = '0;
    logic [N-1:0]  eu_ready;
    logic [N-1:0]  cdb_grant;
    cdb_data_t     eu_data [N];
    cdb_data_t     cdb_data;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.EU_N(N)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush),
        .eu_valid_i  (eu_valid),
        .eu_ready_o  (eu_ready),
        .eu_data_i   (eu_data),
        .cdb_valid_o (cdb_valid),
        .cdb_ready_i (cdb_ready),
        .cdb_data_o  (cdb_data),
        .cdb_grant_o (cdb_grant)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic         rdy;
        logic         fl;
        logic         e_valid;
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        logic [2:0]   e_ptr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add(input logic [N-1:0] v, input logic r, input logic f,
                                input logic ev, input logic [N-1:0] eg,
                                input logic [N-1:0] er, input logic [2:0] ep);
        vec_t t;
        t.valid = v; t.rdy = r; t.fl = f;
        t.e_valid = ev; t.e_grant = eg; t.e_ready = er; t.e_ptr = ep;
        vecs.push_back(t);
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            eu_data[i].rob_idx       = ROB_IDX_W'(i + 15);
            eu_data[i].res_value     = 64'hDEAD_0000 + 64'(i);
            eu_data[i].except_raised = 1'b0;
            eu_data[i].except_code   = 6'(i);
        end

        // valid   rdy  fl   e_valid e_grant e_ready e_ptr
        add(7'h00, 1'b1, 1'b0, 1'b0, 7'h00, 7'h00, 3'd0);  // idle
        add(7'h7F, 1'b1, 1'b0, 1'b1, 7'h01, 7'h01, 3'd1);  // all valid: 0..6
        add(7'h7F, 1'b1, 1'b0, 1'b1, 7'h02, 7'h02, 3'd2);
        add(7'h7F, 1'b1, 1'b0, 1'b1, 7'h04, 7'h04, 3'd3);
        add(7'h7F, 1'b1, 1'b0, 1'b1, 7'h08, 7'h08, 3'd4);
        add(7'h7F, 1'b1, 1'b0, 1'b1, 7'h10, 7'h10, 3'd5);
        add(7'h7F, 1'b1, 1'b0, 1'b1, 7'h20, 7'h20, 3'd6);
        add(7'h7F, 1'b1, 1'b0, 1'b1, 7'h40, 7'h40, 3'd0);  // wrap
        add(7'h7F, 1'b1, 1'b0, 1'b1, 7'h01, 7'h01, 3'd1);
        add(7'h08, 1'b1, 1'b0, 1'b1, 7'h08, 7'h08, 3'd4);  // ALU only: ptr -> 4
        add(7'h18, 1'b1, 1'b0, 1'b1, 7'h10, 7'h10, 3'd5);  // ALU+MULT from 4: MULT
        add(7'h18, 1'b1, 1'b0, 1'b1, 7'h08, 7'h08, 3'd4);  // then ALU
        add(7'h04, 1'b0, 1'b0, 1'b1, 7'h04, 7'h00, 3'd4);  // backpressure x3
        add(7'h04, 1'b0, 1'b0, 1'b1, 7'h04, 7'h00, 3'd4);
        add(7'h04, 1'b0, 1'b0, 1'b1, 7'h04, 7'h00, 3'd4);
        add(7'h04, 1'b1, 1'b0, 1'b1, 7'h04, 7'h04, 3'd3);  // release
        add(7'h04, 1'b0, 1'b0, 1'b1, 7'h04, 7'h00, 3'd3);
        add(7'h0C, 1'b0, 1'b0, 1'b1, 7'h08, 7'h00, 3'd3);  // grant moves under backpressure
        add(7'h0C, 1'b1, 1'b0, 1'b1, 7'h08, 7'h08, 3'd4);
        add(7'h22, 1'b1, 1'b1, 1'b0, 7'h00, 7'h00, 3'd4);  // flush
        add(7'h22, 1'b1, 1'b0, 1'b1, 7'h20, 7'h20, 3'd6);
        add(7'h22, 1'b1, 1'b0, 1'b1, 7'h02, 7'h02, 3'd2);
        add(7'h40, 1'b1, 1'b0, 1'b1, 7'h40, 7'h40, 3'd0);  // single requester
        add(7'h40, 1'b1, 1'b0, 1'b1, 7'h40, 7'h40, 3'd0);
        add(7'h00, 1'b1, 1'b0, 1'b0, 7'h00, 7'h00, 3'd0);

        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_ready", 64'(eu_ready), 64'd0);
        chk("rst_grant", 64'(cdb_grant), 64'd0);
        chk("rst_ptr", 64'(dut.rr_ptr), 64'd0);
`ifdef LEN5_CDB_SPILL_EN
        chk("rst_data", cdb_data.res_value, 64'd0);
`endif
        rst_ni = 1'b1;

`ifndef LEN5_CDB_SPILL_EN
        foreach (vecs[v]) begin
            logic [63:0] exp_rob;
            eu_valid  = vecs[v].valid;
            cdb_ready = vecs[v].rdy;
            flush     = vecs[v].fl;
            exp_rob   = '0;
            for (int k = 0; k < N; k++)
                if (vecs[v].e_grant[k]) exp_rob = 64'(k + 15);
            #1;
            chk($sformatf("v%0d_valid", v), 64'(cdb_valid), 64'(vecs[v].e_valid));
            chk($sformatf("v%0d_grant", v), 64'(cdb_grant), 64'(vecs[v].e_grant));
            chk($sformatf("v%0d_ready", v), 64'(eu_ready), 64'(vecs[v].e_ready));
            if (vecs[v].e_valid)
                chk($sformatf("v%0d_rob", v), 64'(cdb_data.rob_idx), exp_rob);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ptr", v), 64'(dut.rr_ptr), 64'(vecs[v].e_ptr));
        end
        flush = 1'b0;

        // Reset in the middle of back-to-back transfers.
        eu_valid  = 7'h7F;
        cdb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_ptr_pre", 64'(dut.rr_ptr), 64'd2);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ptr", 64'(dut.rr_ptr), 64'd0);
        rst_ni = 1'b1;
        #1;
        chk("mid_rst_grant", 64'(cdb_grant), 64'h01);
        @(posedge clk);
        #1;
        chk("mid_rst_ptr_after", 64'(dut.rr_ptr), 64'd1);
        eu_valid = '0;
`else
        // Streaming from the FPU: output lags the input by one cycle.
        for (int n = 0; n < 6; n++) begin
            eu_valid  = 7'h40;
            cdb_ready = 1'b1;
            eu_data[int'(FPU)].res_value = 64'hDEAD_0000 + 64'(n);
            #1;
            chk($sformatf("spill_ready%0d", n), 64'(eu_ready), 64'h40);
            @(posedge clk);
            #1;
            chk($sformatf("spill_valid%0d", n), 64'(cdb_valid), 64'd1);
            chk($sformatf("spill_data%0d", n), cdb_data.res_value, 64'hDEAD_0000 + 64'(n));
            chk($sformatf("spill_grant%0d", n), 64'(cdb_grant), 64'h40);
            chk($sformatf("spill_ptr%0d", n), 64'(dut.rr_ptr), 64'd0);
        end
        cdb_ready = 1'b0;
        eu_data[int'(FPU)].res_value = 64'hDEAD_0006;
        #1;
        chk("spill_bp_ready", 64'(eu_ready), 64'h00);
        @(posedge clk);
        #1;
        chk("spill_bp_valid", 64'(cdb_valid), 64'd1);
        chk("spill_bp_data", cdb_data.res_value, 64'hDEAD_0005);
        flush = 1'b1;
        #1;
        chk("spill_fl_ready", 64'(eu_ready), 64'h00);
        @(posedge clk);
        #1;
        chk("spill_fl_valid", 64'(cdb_valid), 64'd0);
        chk("spill_fl_grant", 64'(cdb_grant), 64'h00);
        flush    = 1'b0;
        eu_valid = '0;
        @(posedge clk);
        #1;
        chk("spill_idle_valid", 64'(cdb_valid), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus (CDB) among the MAX_EU_N (7) execution-unit result ports: load buffer, store buffer, branch unit, ALU, MULT, DIV, FPU.
- Selects one valid result per cycle with a rotating (round-robin) priority pointer.
- Forwards the selected result to the ROB and the reservation-station snoop logic under a valid/ready handshake.
- Sits between the EU output stages and the commit stage.

Parameters:
- EU_N, MAX_EU_N (7): number of requesters; must be at least 2.
- ROB_IDX_W, $clog2(ROB_DEPTH) (5): width of the ROB tag carried on the CDB.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- flush_i  in  1  pipeline flush on mispredict or exception.
- eu_valid_i  in  EU_N  per-EU result valid.
- eu_ready_o  out  EU_N  per-EU result accepted.
- eu_data_i  in  EU_N x cdb_data_t  per-EU result payload.
- cdb_valid_o  out  1  CDB carries a valid result.
- cdb_ready_i  in  1  ROB accepts the CDB result.
- cdb_data_o  out  cdb_data_t  selected payload.
- cdb_grant_o  out  EU_N  one-hot index of the granted EU; all zeros if none.

Behaviour:
- Reset: rr_ptr=0. All outputs are 0: cdb_valid_o, eu_ready_o, cdb_grant_o, and cdb_data_o (only when LEN5_CDB_SPILL_EN is set).
- Grant is combinational: the first i with eu_valid_i[i]=1, searching rr_ptr, rr_ptr+1, ... mod EU_N. It is one-hot at most.
- No spill (default):
  - cdb_valid_o = |eu_valid_i and !flush_i.
  - cdb_data_o = eu_data_i[grant].
  - eu_ready_o[i] = grant[i] and cdb_ready_i and !flush_i.
  - Latency is 0 cycles.
- Handshake:
  - An EU transfer happens when eu_valid_i[i] and eu_ready_o[i] are both 1.
  - An EU must hold valid and data stable until its transfer.
  - A grant may move to another EU while cdb_ready_i=0 (a higher-priority requester appears); this is legal because ready was not given.
- Pointer update: on a CDB handshake (cdb_valid_o and cdb_ready_i), rr_ptr <= (granted index + 1) mod EU_N. Wrap is from EU_N-1 to 0. Otherwise rr_ptr holds.
- Starvation bound: a continuously valid EU is granted within EU_N handshakes.
- flush_i:
  - Masks every grant and ready in the same cycle.
  - rr_ptr holds.
  - No transfer occurs, even if cdb_ready_i=1.
- A reset asserted mid-transfer wins over everything. The next cycle shows reset values.
- A single requester with cdb_ready_i held at 1 transfers every cycle.

Optional Feature:
- Macro LEN5_CDB_SPILL_EN.
- When defined: a one-entry output register (a spill cell) breaks the combinational path from the EU to the ROB.
  - eu_ready_o[i] = grant[i] and (!reg_valid or cdb_ready_i) and !flush_i.
  - On an EU transfer, the register loads eu_data_i[grant] and sets reg_valid.
  - On a CDB handshake with no new load, reg_valid clears.
  - cdb_valid_o = reg_valid; cdb_data_o and cdb_grant_o are driven from the register.
  - Latency is 1 cycle, with full throughput of 1 per cycle.
  - flush_i clears reg_valid on the next edge and blocks loading.
  - The pointer updates on the EU-side transfer.
- When undefined: fully combinational, as described under Behaviour.

Decomposition:
- Package len5_pkg holds:
  - cdb_data_t, a packed struct: rob_idx [ROB_IDX_W], res_value [64], except_raised [1], except_code [6]; 76 bits at the defaults.
  - The constant EU index enumeration eu_idx_t: LDBUFF=0, STBUFF=1, BU=2, ALU=3, MULT=4, DIV=5, FPU=6.
- Sub-module rr_prio_encoder (EU_N): inputs are the request vector and rr_ptr; the output is the one-hot grant. It is purely combinational and reusable by the reservation-station arbiters.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles, then eu_valid_i=0 → cdb_valid_o=0, eu_ready_o=0, rr_ptr=0.
- All 7 valid, cdb_ready_i=1 for 7 cycles → grants in order 0,1,2,3,4,5,6, then 0 again. Each EU sees exactly one ready per 7 cycles.
- Only ALU (3) and MULT (4) valid, rr_ptr=4, cdb_ready_i=1 → MULT granted first, then ALU; rr_ptr reads 4 (after ALU).
- Backpressure: EU 2 valid with rob_idx=5'd17 and cdb_ready_i=0 for 3 cycles → cdb_valid_o=1, cdb_data_o.rob_idx=17, eu_ready_o=0, rr_ptr unchanged. Ready goes to 1 → one transfer.
- Flush: EUs 1 and 5 valid, cdb_ready_i=1, flush_i=1 → cdb_valid_o=0, eu_ready_o=0, rr_ptr held. With LEN5_CDB_SPILL_EN, a pending reg_valid drops next cycle.
- Spill build: EU 6 valid each cycle with res_value=64'hDEAD_0000+n, cdb_ready_i=1 → cdb_data_o lags by one cycle, one result per cycle, none dropped or duplicated.
